// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: walks the shared-memory / shared-ALU datapath
// through fetch, decode, execute, memory and writeback. Supports R-type
// add/sub/and/or/slt, lw/lh/lb/sw, beq/bne, addi/andi/ori and j.
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcen,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               zeroext,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               half,
  output logic               b,
  output logic               illegal,
  output logic [STATE_W-1:0] dbg_state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LH   = 6'b100001;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BRANCH  = 4'd8,
    IMMEX   = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       op_known;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic [2:0] imm_alu;
  logic       pcwrite;
  logic       branch;
  logic       ne;
  logic       irwrite_reg;
  logic       memwrite_reg;
  logic       regwrite_reg;
  logic       load_half;
  logic       load_byte;

  // Decode the opcode and funct fields into legality flags and ALU operations
  always_comb begin
    op_known  = 1'b0;
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    imm_alu   = ALU_ADD;
    case (op)
      OP_R, OP_LW, OP_LH, OP_LB, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ANDI, OP_ORI, OP_J: op_known = 1'b1;
      default:                        op_known = 1'b0;
    endcase
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
    case (op)
      OP_ANDI: imm_alu = ALU_AND;
      OP_ORI:  imm_alu = ALU_OR;
      default: imm_alu = ALU_ADD;
    endcase
  end

  // Next-state selection; unused encodings fall back to FETCH
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_LH, OP_LB, OP_SW: next_state = MEMADR;
          OP_R:                       next_state = RTYPEEX;
          OP_BEQ, OP_BNE:             next_state = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:   next_state = IMMEX;
          OP_J:                       next_state = JUMP;
          default:                    next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   next_state = MEMWB;
      RTYPEEX: next_state = funct_ok ? RTYPEWB : FETCH;
      IMMEX:   next_state = IMMWB;
      default: next_state = FETCH;
    endcase
  end

  // State register with Moore outputs registered from the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FETCH;
      iord         <= 1'b0;
      irwrite_reg  <= 1'b1;
      memwrite_reg <= 1'b0;
      regdst       <= 1'b0;
      memtoreg     <= 1'b0;
      regwrite_reg <= 1'b0;
      alusrca      <= 1'b0;
      alusrcb      <= 2'b01;
      zeroext      <= 1'b0;
      pcsrc        <= 2'b00;
      alucontrol   <= ALU_ADD;
      half         <= 1'b0;
      b            <= 1'b0;
      pcwrite      <= 1'b1;
      branch       <= 1'b0;
      ne           <= 1'b0;
      load_half    <= 1'b0;
      load_byte    <= 1'b0;
    end else begin
      state        <= next_state;
      iord         <= 1'b0;
      irwrite_reg  <= 1'b0;
      memwrite_reg <= 1'b0;
      regdst       <= 1'b0;
      memtoreg     <= 1'b0;
      regwrite_reg <= 1'b0;
      alusrca      <= 1'b0;
      alusrcb      <= 2'b00;
      zeroext      <= 1'b0;
      pcsrc        <= 2'b00;
      alucontrol   <= ALU_ADD;
      half         <= 1'b0;
      b            <= 1'b0;
      pcwrite      <= 1'b0;
      branch       <= 1'b0;
      ne           <= 1'b0;
      if (state == MEMADR) begin
        load_half <= (op == OP_LH);
        load_byte <= (op == OP_LB);
      end else if (state == FETCH) begin
        load_half <= 1'b0;
        load_byte <= 1'b0;
      end
      case (next_state)
        FETCH: begin
          irwrite_reg <= 1'b1;
          alusrcb     <= 2'b01;
          pcwrite     <= 1'b1;
        end
        DECODE: alusrcb <= 2'b11;
        MEMADR: begin
          alusrca <= 1'b1;
          alusrcb <= 2'b10;
        end
        MEMRD: iord <= 1'b1;
        MEMWB: begin
          memtoreg     <= 1'b1;
          regwrite_reg <= 1'b1;
          half         <= load_half;
          b            <= load_byte;
        end
        MEMWR: begin
          iord         <= 1'b1;
          memwrite_reg <= 1'b1;
        end
        RTYPEEX: begin
          alusrca    <= 1'b1;
          alucontrol <= funct_alu;
        end
        RTYPEWB: begin
          regdst       <= 1'b1;
          regwrite_reg <= 1'b1;
        end
        BRANCH: begin
          alusrca    <= 1'b1;
          alucontrol <= ALU_SUB;
          pcsrc      <= 2'b01;
          branch     <= 1'b1;
          ne         <= (op == OP_BNE);
        end
        IMMEX: begin
          alusrca    <= 1'b1;
          alusrcb    <= 2'b10;
          alucontrol <= imm_alu;
          zeroext    <= (op == OP_ANDI) || (op == OP_ORI);
        end
        IMMWB: regwrite_reg <= 1'b1;
        JUMP: begin
          pcsrc   <= 2'b10;
          pcwrite <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Write enables and the illegal pulse are masked by reset so they drop
  // the moment reset rises; illegal depends on the IR contents directly
  // because the IR is only loaded on the edge that enters DECODE
  always_comb begin
    irwrite  = irwrite_reg & ~reset;
    memwrite = memwrite_reg & ~reset;
    regwrite = regwrite_reg & ~reset;
    pcen     = (pcwrite | (branch & (zero ^ ne))) & ~reset;
    illegal  = ~reset & (((state == DECODE) & ~op_known) |
                         ((state == RTYPEEX) & ~funct_ok));
  end

  assign dbg_state = STATE_W'(state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl: walks each instruction class
// through its state sequence and compares control outputs against
// hand-derived values.
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       alusrca, zeroext, half, b, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] dbg_state;

  int checks;
  int failures;

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .half(half), .b(b), .illegal(illegal),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 6'b000000; funct = 6'b100000; zero = 1'b0;
    #3;
    checks++; if (dbg_state !== 4'd0) begin failures++; $display("[TB] FAIL reset_state got=%0d exp=0", dbg_state); end
    checks++; if (irwrite !== 1'b0) begin failures++; $display("[TB] FAIL reset_irwrite got=%b exp=0", irwrite); end
    checks++; if (pcen !== 1'b0) begin failures++; $display("[TB] FAIL reset_pcen got=%b exp=0", pcen); end
    checks++; if (alusrcb !== 2'b01) begin failures++; $display("[TB] FAIL reset_alusrcb got=%b exp=01", alusrcb); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (irwrite !== 1'b1 || pcen !== 1'b1) begin failures++; $display("[TB] FAIL release_fetch got irwrite=%b pcen=%b exp=1/1", irwrite, pcen); end
  endtask

  task automatic test_loads(input logic [5:0] opc, input logic exp_half, input logic exp_b, input string name);
    op = opc;
    step();
    checks++; if (dbg_state !== 4'd1 || alusrcb !== 2'b11) begin failures++; $display("[TB] FAIL %s_decode got state=%0d alusrcb=%b exp=1/11", name, dbg_state, alusrcb); end
    step();
    checks++; if (dbg_state !== 4'd2 || alusrca !== 1'b1 || alusrcb !== 2'b10) begin failures++; $display("[TB] FAIL %s_memadr got state=%0d a=%b b=%b exp=2/1/10", name, dbg_state, alusrca, alusrcb); end
    step();
    checks++; if (dbg_state !== 4'd3 || iord !== 1'b1) begin failures++; $display("[TB] FAIL %s_memrd got state=%0d iord=%b exp=3/1", name, dbg_state, iord); end
    step();
    checks++; if (dbg_state !== 4'd4 || b !== exp_b || half !== exp_half || memtoreg !== 1'b1 || regwrite !== 1'b1) begin
      failures++; $display("[TB] FAIL %s_memwb got state=%0d b=%b half=%b m2r=%b rw=%b exp=4/%b/%b/1/1", name, dbg_state, b, half, memtoreg, regwrite, exp_b, exp_half);
    end
    step();
    checks++; if (dbg_state !== 4'd0 || half !== 1'b0 || b !== 1'b0) begin failures++; $display("[TB] FAIL %s_done got state=%0d half=%b b=%b exp=0/0/0", name, dbg_state, half, b); end
  endtask

  task automatic test_sw();
    op = 6'b101011;
    step(); step(); step();
    checks++; if (dbg_state !== 4'd5 || memwrite !== 1'b1 || iord !== 1'b1 || regwrite !== 1'b0) begin
      failures++; $display("[TB] FAIL sw_memwr got state=%0d mw=%b iord=%b rw=%b exp=5/1/1/0", dbg_state, memwrite, iord, regwrite);
    end
    step();
    checks++; if (dbg_state !== 4'd0 || memwrite !== 1'b0) begin failures++; $display("[TB] FAIL sw_done got state=%0d mw=%b exp=0/0", dbg_state, memwrite); end
  endtask

  task automatic test_branch(input logic [5:0] opc, input logic z, input logic exp_pcen, input string name);
    op = opc; zero = z;
    step(); step();
    checks++; if (dbg_state !== 4'd8 || pcen !== exp_pcen || pcsrc !== 2'b01 || alucontrol !== 3'b110) begin
      failures++; $display("[TB] FAIL %s got state=%0d pcen=%b pcsrc=%b alu=%b exp=8/%b/01/110", name, dbg_state, pcen, pcsrc, alucontrol, exp_pcen);
    end
    zero = ~z;
    #1;
    checks++; if (pcen !== ~exp_pcen) begin failures++; $display("[TB] FAIL %s_flip got pcen=%b exp=%b", name, pcen, ~exp_pcen); end
    step();
    checks++; if (dbg_state !== 4'd0) begin failures++; $display("[TB] FAIL %s_done got state=%0d exp=0", name, dbg_state); end
    zero = 1'b0;
  endtask

  task automatic test_ori();
    op = 6'b001101;
    step(); step();
    checks++; if (dbg_state !== 4'd9 || zeroext !== 1'b1 || alucontrol !== 3'b001 || alusrcb !== 2'b10) begin
      failures++; $display("[TB] FAIL ori_immex got state=%0d zext=%b alu=%b srcb=%b exp=9/1/001/10", dbg_state, zeroext, alucontrol, alusrcb);
    end
    step();
    checks++; if (dbg_state !== 4'd10 || regwrite !== 1'b1 || regdst !== 1'b0 || memtoreg !== 1'b0) begin
      failures++; $display("[TB] FAIL ori_immwb got state=%0d rw=%b rd=%b m2r=%b exp=10/1/0/0", dbg_state, regwrite, regdst, memtoreg);
    end
    step();
    checks++; if (dbg_state !== 4'd0) begin failures++; $display("[TB] FAIL ori_done got state=%0d exp=0", dbg_state); end
  endtask

  task automatic test_addi();
    op = 6'b001000;
    step(); step();
    checks++; if (zeroext !== 1'b0 || alucontrol !== 3'b010) begin failures++; $display("[TB] FAIL addi_immex got zext=%b alu=%b exp=0/010", zeroext, alucontrol); end
    step(); step();
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [2:0] exp_alu, input string name);
    op = 6'b000000; funct = fn;
    step(); step();
    checks++; if (dbg_state !== 4'd6 || alucontrol !== exp_alu || alusrca !== 1'b1 || alusrcb !== 2'b00 || illegal !== 1'b0) begin
      failures++; $display("[TB] FAIL %s_ex got state=%0d alu=%b a=%b b=%b ill=%b exp=6/%b/1/00/0", name, dbg_state, alucontrol, alusrca, alusrcb, illegal, exp_alu);
    end
    step();
    checks++; if (dbg_state !== 4'd7 || regdst !== 1'b1 || regwrite !== 1'b1) begin
      failures++; $display("[TB] FAIL %s_wb got state=%0d rd=%b rw=%b exp=7/1/1", name, dbg_state, regdst, regwrite);
    end
    step();
    checks++; if (dbg_state !== 4'd0) begin failures++; $display("[TB] FAIL %s_done got state=%0d exp=0", name, dbg_state); end
  endtask

  task automatic test_jump();
    op = 6'b000010;
    step(); step();
    checks++; if (dbg_state !== 4'd11 || pcsrc !== 2'b10 || pcen !== 1'b1) begin
      failures++; $display("[TB] FAIL j got state=%0d pcsrc=%b pcen=%b exp=11/10/1", dbg_state, pcsrc, pcen);
    end
    step();
    checks++; if (dbg_state !== 4'd0) begin failures++; $display("[TB] FAIL j_done got state=%0d exp=0", dbg_state); end
  endtask

  task automatic test_illegal_op();
    op = 6'b111111;
    checks++; if (illegal !== 1'b0) begin failures++; $display("[TB] FAIL ill_fetch got=%b exp=0", illegal); end
    step();
    checks++; if (dbg_state !== 4'd1 || illegal !== 1'b1 || regwrite !== 1'b0 || memwrite !== 1'b0) begin
      failures++; $display("[TB] FAIL ill_decode got state=%0d ill=%b rw=%b mw=%b exp=1/1/0/0", dbg_state, illegal, regwrite, memwrite);
    end
    step();
    checks++; if (dbg_state !== 4'd0 || illegal !== 1'b0 || regwrite !== 1'b0 || memwrite !== 1'b0) begin
      failures++; $display("[TB] FAIL ill_after got state=%0d ill=%b rw=%b mw=%b exp=0/0/0/0", dbg_state, illegal, regwrite, memwrite);
    end
  endtask

  task automatic test_bad_funct();
    op = 6'b000000; funct = 6'b000111;
    step(); step();
    checks++; if (dbg_state !== 4'd6 || illegal !== 1'b1 || alucontrol !== 3'b010) begin
      failures++; $display("[TB] FAIL badfn_ex got state=%0d ill=%b alu=%b exp=6/1/010", dbg_state, illegal, alucontrol);
    end
    step();
    checks++; if (dbg_state !== 4'd0 || regwrite !== 1'b0 || illegal !== 1'b0) begin
      failures++; $display("[TB] FAIL badfn_after got state=%0d rw=%b ill=%b exp=0/0/0", dbg_state, regwrite, illegal);
    end
    funct = 6'b100000;
  endtask

  task automatic test_reset_mid();
    op = 6'b100011;
    step(); step(); step(); step();
    checks++; if (dbg_state !== 4'd4 || regwrite !== 1'b1) begin failures++; $display("[TB] FAIL mid_memwb got state=%0d rw=%b exp=4/1", dbg_state, regwrite); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (regwrite !== 1'b0 || dbg_state !== 4'd0) begin failures++; $display("[TB] FAIL mid_abort got rw=%b state=%0d exp=0/0", regwrite, dbg_state); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (irwrite !== 1'b1 || pcen !== 1'b1 || dbg_state !== 4'd0) begin
      failures++; $display("[TB] FAIL mid_release got irwrite=%b pcen=%b state=%0d exp=1/1/0", irwrite, pcen, dbg_state);
    end
    step();
    checks++; if (dbg_state !== 4'd1) begin failures++; $display("[TB] FAIL mid_first_fetch got state=%0d exp=1", dbg_state); end
    step(); step(); step(); step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_loads(6'b100000, 1'b0, 1'b1, "lb");
    test_loads(6'b100001, 1'b1, 1'b0, "lh");
    test_loads(6'b100011, 1'b0, 1'b0, "lw");
    test_sw();
    test_branch(6'b000101, 1'b0, 1'b1, "bne_z0");
    test_branch(6'b000101, 1'b1, 1'b0, "bne_z1");
    test_branch(6'b000100, 1'b1, 1'b1, "beq_z1");
    test_ori();
    test_addi();
    test_rtype(6'b101010, 3'b111, "slt");
    test_rtype(6'b100010, 3'b110, "sub");
    test_rtype(6'b100100, 3'b000, "and");
    test_jump();
    test_illegal_op();
    test_bad_funct();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Moore-style control FSM that sequences a multicycle MIPS datapath, with one shared memory and one shared ALU, through fetch/decode/execute/memory/writeback steps. It decodes op/funct and supports the team's extended load set: lw, lh, lb. It also supports bne, zero-extended immediates (andi/ori) and j. It sits beside the datapath and drives every mux select and write enable each cycle.

Parameters:
STATE_W, 4, width of state register and dbg_state port

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
op  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0] from instruction register
zero  input  1  ALU zero flag, valid in branch state
pcen  output  1  PC register enable
iord  output  1  memory address select: 0=PC, 1=ALUOut
memwrite  output  1  data memory write enable
irwrite  output  1  instruction register load enable
regdst  output  1  write register: 0=rt, 1=rd
memtoreg  output  1  writeback: 0=ALUOut, 1=memory data
regwrite  output  1  register file write enable
alusrca  output  1  ALU A: 0=PC, 1=rs register
alusrcb  output  2  ALU B: 00=rt reg, 01=const 4, 10=ext imm, 11=signimm<<2
zeroext  output  1  immediate extension: 0=sign, 1=zero
pcsrc  output  2  00=ALU result, 01=ALUOut, 10=jump target
alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
half  output  1  select sign-extended halfword load result
b  output  1  select sign-extended byte load result
illegal  output  1  one-cycle pulse on unsupported op/funct
dbg_state  output  STATE_W  current state encoding

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (reset); the state register goes to FETCH immediately.
- Outputs during reset: while reset=1, pcen, irwrite, memwrite, regwrite and illegal are forced to 0. All other outputs take their FETCH values.
- Defaults: any output not listed for a state is 0 in that state.
- Opcodes: R=000000, lw=100011, lh=100001, lb=100000, sw=101011, beq=000100, bne=000101, addi=001000, andi=001100, ori=001101, j=000010.
- Funct codes: add=100000, sub=100010, and=100100, or=100101, slt=101010.
- States and their outputs:
  - FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, pcwrite=1.
  - DECODE: alusrca=0, alusrcb=11, alucontrol=010 (branch target into ALUOut).
  - MEMADR: alusrca=1, alusrcb=10, alucontrol=010.
  - MEMRD: iord=1.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. half=1 for lh; b=1 for lb. The load kind is latched in MEMADR and held until FETCH.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1.
  - BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1. The ne term is 1 when op=bne.
  - IMMEX: alusrca=1, alusrcb=10. alucontrol is 010 for addi, 000 for andi, 001 for ori. zeroext=1 for andi/ori.
  - IMMWB: regdst=0, memtoreg=0, regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- pcen is combinational: pcen = pcwrite | (branch & (zero XOR ne)).
- Transitions:
  - FETCH->DECODE.
  - DECODE: lw/lh/lb/sw->MEMADR; R->RTYPEEX; beq/bne->BRANCH; addi/andi/ori->IMMEX; j->JUMP; other op->FETCH with illegal=1 in DECODE.
  - MEMADR: loads->MEMRD, sw->MEMWR.
  - MEMRD->MEMWB->FETCH.
  - MEMWR->FETCH.
  - RTYPEEX->RTYPEWB->FETCH.
  - IMMEX->IMMWB->FETCH.
  - BRANCH->FETCH.
  - JUMP->FETCH.
- Unknown funct in RTYPEEX: illegal=1, alucontrol=010, next state FETCH. No register write occurs.
- Latency (cycles, FETCH inclusive): loads 5; R-type, sw and immediate ops 4; branch and j 3.
- Illegal state encodings: return to FETCH on the next edge.
- op/funct are sampled only in DECODE, MEMADR, RTYPEEX, BRANCH and IMMEX. The IR is stable in those states because irwrite is 0.
- Reset mid-instruction: the state aborts to FETCH. No write enable may assert during reset or on the cycle it deasserts. The first post-reset edge performs a fetch.

Test Plan:
- Reset asserted mid-MEMWB (lw) -> regwrite drops to 0 in the same cycle without a clock edge. dbg_state=FETCH; after release, irwrite=1 and pcen=1.
- op=100000 (lb) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. In MEMWB: b=1, half=0, memtoreg=1, regwrite=1. Total 5 cycles.
- op=000101 (bne) with zero=0 in BRANCH -> pcen=1, pcsrc=01. Same op with zero=1 -> pcen=0. beq with zero=1 -> pcen=1.
- op=001101 (ori) -> in IMMEX: zeroext=1, alucontrol=001, alusrcb=10. In IMMWB: regwrite=1, regdst=0.
- op=000000, funct=101010 (slt) -> alucontrol=111 in RTYPEEX, then regdst=1 and regwrite=1 in RTYPEWB.
- op=111111 -> illegal=1 for the single DECODE cycle, then FETCH, with no regwrite or memwrite at any point. funct=000111 with op=0 -> illegal in RTYPEEX and no RTYPEWB.
